// File: rtl/arm_mem_responder_pkg.sv
// Shared types and helpers for the ARM pipeline memory responder.
package arm_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } resp_state_e;

    // Value presented on IC whenever a fetch is not served.
    localparam logic [31:0] IC_NOP = 32'h0;

    // True when the low 'lsbs' bits of a byte address are zero.
    function automatic logic is_aligned(input logic [63:0] addr, input int unsigned lsbs);
        return (addr & ((64'd1 << lsbs) - 64'd1)) == 64'd0;
    endfunction

    // True when a word index falls inside an array of 'words' entries.
    function automatic logic in_range(input logic [63:0] idx, input int unsigned words);
        return idx < 64'(words);
    endfunction

endpackage

// File: rtl/arm_mem_responder_ic_loader.sv
// Streaming program loader: accepts one instruction word per cycle into IMEM
// while loading is enabled, counts accepted words, and serves the fetch read port.
module ic_loader #(
    parameter int IMEM_WORDS = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_en_i,
    input  logic                          ld_valid_i,
    input  logic [31:0]                   ld_data_i,
    input  logic                          ld_last_i,
    input  logic [$clog2(IMEM_WORDS)-1:0] rd_idx_i,
    output logic                          ld_ready_o,
    output logic [$clog2(IMEM_WORDS):0]   load_count_o,
    output logic                          load_done_o,
    output logic [31:0]                   rd_data_o
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int CW = IW + 1;

    logic [31:0]   imem_q [IMEM_WORDS];
    logic [CW-1:0] count_q, count_d;
    logic          accept;

    assign ld_ready_o   = load_en_i && (count_q < CW'(IMEM_WORDS));
    assign accept       = ld_valid_i && ld_ready_o;
    assign count_d      = count_q + CW'(1);
    // Loading ends on the tagged last beat or on the beat that fills IMEM.
    assign load_done_o  = accept && (ld_last_i || (count_q == CW'(IMEM_WORDS - 1)));
    assign load_count_o = count_q;
    assign rd_data_o    = imem_q[rd_idx_i];

    // Accepted-word counter; reset discards any partial image.
    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else if (accept) count_q <= count_d;
    end

    // IMEM write port, filled in order at the current count.
    always_ff @(posedge clk_i) begin
        if (accept && !rst_i) imem_q[count_q[IW-1:0]] <= ld_data_i;
    end

endmodule

// File: rtl/arm_mem_responder.sv
// Memory-side responder for the five-stage ARM pipeline: combinational fetch and
// load data, clocked stores, post-reset DMEM clear sweep and program loader.
module arm_mem_responder
    import arm_mem_responder_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 128
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic [63:0]                 PC,
    output logic [31:0]                 IC,
    input  logic [63:0]                 mem_address_in,
    input  logic [63:0]                 mem_data_in,
    input  logic                        mem_read,
    input  logic                        mem_write,
    output logic [63:0]                 mem_data_out,
    input  logic                        ld_valid,
    input  logic [31:0]                 ld_data,
    input  logic                        ld_last,
    output logic                        ld_ready,
    output logic                        cpu_reset,
    output logic                        err_misalign,
    output logic                        err_range,
    output logic [$clog2(IMEM_WORDS):0] load_count
);
    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    resp_state_e   state_q;
    logic [DW-1:0] clear_ptr_q;
    logic          err_misalign_q, err_misalign_d;
    logic          err_range_q, err_range_d;
    logic [63:0]   dmem_q [DMEM_WORDS];

    logic          run, load_en, load_done;
    logic [63:0]   fetch_idx, d_idx;
    logic          fetch_aligned, fetch_inrange, fetch_loaded;
    logic          d_acc, d_aligned, d_inrange, d_ok;
    logic [31:0]   imem_rd;

    assign run     = (state_q == ST_RUN);
    assign load_en = (state_q == ST_LOAD);

    assign fetch_idx     = PC >> 2;
    assign fetch_aligned = is_aligned(PC, 2);
    assign fetch_inrange = in_range(fetch_idx, IMEM_WORDS);
    // load_count never exceeds IMEM_WORDS, so this also implies in-range.
    assign fetch_loaded  = fetch_idx < 64'(load_count);

    assign d_idx     = mem_address_in >> 3;
    assign d_aligned = is_aligned(mem_address_in, 3);
    assign d_inrange = in_range(d_idx, DMEM_WORDS);
    assign d_acc     = run && (mem_read || mem_write);
    assign d_ok      = run && d_aligned && d_inrange;

    ic_loader #(.IMEM_WORDS(IMEM_WORDS)) u_ic_loader (
        .clk_i        (CLOCK),
        .rst_i        (RESET),
        .load_en_i    (load_en),
        .ld_valid_i   (ld_valid),
        .ld_data_i    (ld_data),
        .ld_last_i    (ld_last),
        .rd_idx_i     (fetch_idx[IW-1:0]),
        .ld_ready_o   (ld_ready),
        .load_count_o (load_count),
        .load_done_o  (load_done),
        .rd_data_o    (imem_rd)
    );

    // Zero-latency read paths; the CPU latches these at the same edge.
    assign IC           = (run && fetch_aligned && fetch_loaded) ? imem_rd : IC_NOP;
    assign mem_data_out = (d_ok && mem_read) ? dmem_q[d_idx[DW-1:0]] : 64'h0;
    assign cpu_reset    = !run;
    assign err_misalign = err_misalign_q;
    assign err_range    = err_range_q;

    // Sticky error accumulation, only while the CPU is running.
    always_comb begin
        err_misalign_d = err_misalign_q;
        err_range_d    = err_range_q;
        if (run) begin
            if (!fetch_aligned || (d_acc && !d_aligned)) err_misalign_d = 1'b1;
            if (!fetch_inrange || (d_acc && !d_inrange)) err_range_d    = 1'b1;
        end
    end

    // Responder FSM: clear sweep, program load, then run.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q        <= ST_CLEAR;
            clear_ptr_q    <= '0;
            err_misalign_q <= 1'b0;
            err_range_q    <= 1'b0;
        end else begin
            err_misalign_q <= err_misalign_d;
            err_range_q    <= err_range_d;
            case (state_q)
                ST_CLEAR: begin
                    clear_ptr_q <= clear_ptr_q + DW'(1);
                    if (clear_ptr_q == DW'(DMEM_WORDS - 1)) state_q <= ST_LOAD;
                end
                ST_LOAD:  if (load_done) state_q <= ST_RUN;
                ST_RUN:   state_q <= ST_RUN;
                default:  state_q <= ST_CLEAR;
            endcase
        end
    end

    // DMEM write port: sweep zeros during CLEAR, CPU stores during RUN.
    // A read in the same cycle sees the pre-store contents.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            if (state_q == ST_CLEAR) dmem_q[clear_ptr_q] <= 64'h0;
            else if (d_ok && mem_write) dmem_q[d_idx[DW-1:0]] <= mem_data_in;
        end
    end

endmodule

// File: doc/arm_mem_responder.md
# arm_mem_responder

Memory-side responder for the five-stage ARM pipeline: serves instruction fetch (PC in, IC out) and the data port (address, write data, read/write strobes in, read data out) with the exact combinational-read/clocked-write timing the pipeline's IF/ID and MEM/WB latches expect. Adds a post-reset DMEM clear sweep and a streaming program loader that holds the CPU in reset until the image is in IMEM. Sits beside the CPU in the SoC top level, replacing testbench-side memory models.

## Interface
- IMEM_WORDS, 256: 32-bit instruction words; power of two.
- DMEM_WORDS, 128: 64-bit doublewords; power of two.
- CLOCK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high.
- PC  in  64  CPU fetch address (byte).
- IC  out  32  instruction at PC.
- mem_address_in  in  64  CPU data address (byte).
- mem_data_in  in  64  CPU store data.
- mem_read  in  1  CPU load strobe.
- mem_write  in  1  CPU store strobe.
- mem_data_out  out  64  load data to CPU.
- ld_valid  in  1  loader word present.
- ld_data  in  32  instruction word to load.
- ld_last  in  1  marks final image word.
- ld_ready  out  1  responder accepts ld_data this cycle.
- cpu_reset  out  1  hold CPU in reset.
- err_misalign  out  1  sticky: misaligned data or fetch access.
- err_range  out  1  sticky: out-of-range data or fetch access.
- load_count  out  $clog2(IMEM_WORDS)+1  words loaded.

## Operation
- FSM states CLEAR, LOAD, RUN. RESET (any state, any cycle) -> CLEAR; clear_ptr=0, load_count=0, errors=0.
- CLEAR: one DMEM word zeroed per cycle at clear_ptr, ptr++; after word DMEM_WORDS-1 -> LOAD. CPU data strobes ignored.
- LOAD: ld_ready=1 while load_count<IMEM_WORDS. ld_valid&&ld_ready writes imem[load_count], load_count++. Transition to RUN on accepted beat with ld_last, or accepted beat filling IMEM_WORDS. ld_ready=0 in CLEAR and RUN; ld_valid then ignored.
- RUN: cpu_reset=0. Stores: mem_write && aligned && in range -> dmem[addr>>3] <= mem_data_in at edge.
- Fetch: index=PC>>2. IC=imem[index] if PC[1:0]==0, index<load_count, and state RUN; else 32'h0. PC[1:0]!=0 in RUN sets err_misalign; index>=IMEM_WORDS in RUN sets err_range.
- Data read: mem_data_out=dmem[addr>>3] when mem_read && aligned (addr[2:0]==0) && addr>>3<DMEM_WORDS && state RUN; else 64'h0.
- Misaligned data access (either strobe, RUN) -> ignored, err_misalign set. Out-of-range -> ignored, err_range set.
- mem_read && mem_write same cycle: store performed; mem_data_out shows pre-store contents.
- Error flags sticky until RESET.

## Timing
- Reset values: IC=0, mem_data_out=0, ld_ready=0, cpu_reset=1, err_*=0, load_count=0.
- cpu_reset=1 in CLEAR and LOAD; falls first cycle in RUN.
- CLEAR lasts exactly DMEM_WORDS cycles after RESET deasserts.
- IC and mem_data_out combinational from current inputs and array contents (zero-latency); CPU latches them at the same edge.
- Store visible to reads the cycle after its edge; same-cycle read-during-write returns old data.
- Loader: one word per cycle max; load_count updates at accepting edge; state is RUN the cycle after the ld_last beat.
- RESET mid-LOAD discards progress; IMEM contents stale but masked by load_count=0.

## Structure
- Shared package: state encoding (CLEAR/LOAD/RUN), alignment/range helper functions, IC_NOP=32'h0 constant.
- Sub-module ic_loader: LOAD-state handshake, load_count, IMEM write port. DMEM array, clear sweep, and data port remain top level.

## Test plan
- RESET 1 cycle with DMEM_WORDS=128 -> cpu_reset=1, ld_ready=0 for 128 cycles, then ld_ready=1; every dmem read after RUN returns 0.
- Load 32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003 (ld_last on third, ld_valid gapped) -> load_count=3, RUN next cycle; PC=8 -> IC=32'hAAAA0003; PC=12 -> IC=0.
- RUN: store 64'hDEADBEEF_00000001 to addr 16, same-cycle read of 16 -> old 0; next cycle read 16 -> 64'hDEADBEEF_00000001.
- Store to addr 20 -> no write, err_misalign=1 persists; read addr 1024 (DMEM_WORDS=128) -> mem_data_out=0, err_range=1.
- Fill IMEM with 256 beats, no ld_last -> RUN after beat 256, ld_ready=0.
- RESET after 2 loaded words -> CLEAR, load_count=0, cpu_reset=1, errors cleared; PC=0 -> IC=0 until reloaded.
